operand_pattern_gen: RTL and testbench
======================================

// Module: operand_pattern_gen
// PURPOSE
//   Upstream stimulus stage for the 2-bit operand block `behave` (inputs a, b).
//   Replays an alternating invert-a / invert-b operand sequence with programmable
//   hold gaps, which replaces hand-written #delay stimulus.
//   Each operand pair is presented with a valid/ready handshake.
//   Hold timing is counted in clock cycles and starts only after the pair is accepted.
// PARAMETERS
//   WIDTH      2    operand width of a and b
//   INIT_A     1    value loaded into a on start
//   INIT_B     0    value loaded into b on start
//   HOLD_A     50   idle cycles before an a-inversion step (>=1)
//   HOLD_B     100  idle cycles before a b-inversion step (>=1)
//   NUM_STEPS  4    inversion steps after the initial pair (>=1)
//   CNT_W      8    hold-timer width; must hold max(HOLD_A,HOLD_B)
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous reset, active low
//   start      in   1      begin sequence (honoured in IDLE/DONE only)
//   abort      in   1      return to IDLE; priority over start
//   out_ready  in   1      downstream accepts current pair
//   out_valid  out  1      a/b pair valid
//   a          out  WIDTH  operand a (registered)
//   b          out  WIDTH  operand b (registered)
//   busy       out  1      high in PRESENT or WAIT
//   done       out  1      high in DONE
// BEHAVIOUR
//   Reset (rst_n=0 at edge): state=IDLE, a=0, b=0, out_valid=0, busy=0, done=0, k=0, timer=0.
//   States: IDLE, PRESENT, WAIT, DONE. k = index of the pair being presented (0..NUM_STEPS).
//   IDLE/DONE + start:
//     - next cycle a=INIT_A, b=INIT_B, k=0, out_valid=1, go to PRESENT.
//     - done clears in the same cycle.
//   PRESENT:
//     - out_valid=1; a/b stay stable until out_valid&&out_ready.
//     - On handshake, out_valid=0 next cycle.
//     - If k==NUM_STEPS, go to DONE.
//     - Otherwise go to WAIT with timer=HOLD_A (k even) or HOLD_B (k odd).
//   WAIT:
//     - timer decrements each cycle.
//     - In the cycle timer==1, next edge: k even -> a<=~a, k odd -> b<=~b; k<=k+1; out_valid=1; PRESENT.
//     - Result: out_valid stays low for exactly HOLD cycles after the handshake cycle.
//   DONE: a/b hold the last pair; done=1 until start or abort.
//   start in PRESENT/WAIT is ignored.
//   abort (any state, incl. mid-WAIT):
//     - next cycle IDLE; out_valid=0, busy=0, done=0, a=0, b=0.
//     - abort+start in the same cycle -> abort wins.
//   out_ready while out_valid=0 has no effect.
//   Inversion wraps naturally in WIDTH bits; no arithmetic carry.
// CONFIGURATION
//   OPGEN_LOOP_EN defined:
//     - after the NUM_STEPS handshake, skip DONE.
//     - next cycle reload INIT_A/INIT_B, k=0, out_valid=1 in PRESENT.
//     - repeat until abort; done never asserts.
//   OPGEN_LOOP_EN undefined: behaviour as above (terminates in DONE).
// TESTING (defaults, out_ready=1 unless stated)
//   1. Reset with rst_n=0 for 2 cycles -> a=00, b=00, out_valid=0, busy=0, done=0.
//   2. Full sequence: start pulse -> accepted pairs in order (01,00),(10,00),(10,11),(01,11),(01,00).
//      Gaps of exactly 50,100,50,100 low cycles between them; done=1 after the 5th accept.
//   3. Backpressure: hold out_ready=0 for 20 cycles on pair (10,00) -> a/b/out_valid stable.
//      WAIT timer does not start until the handshake.
//   4. abort at the 30th cycle of the first WAIT -> next cycle IDLE, a=b=00.
//      A start issued 1 cycle later restarts from (01,00).
//   5. start during WAIT, and start+abort together in DONE -> start is ignored; abort wins (IDLE).
//   6. OPGEN_LOOP_EN: after the 5th accept, the next cycle presents (01,00) with out_valid=1.
//      done stays 0 through 2 full loops.

Source files
------------

// File: rtl/operand_pattern_gen.sv
// operand_pattern_gen: stimulus source for the 2-bit operand block `behave`.
// Replays an alternating invert-a / invert-b operand sequence, presenting each
// pair over a valid/ready handshake, with a programmable idle gap after each
// accepted pair.
// Optional build macro: OPGEN_LOOP_EN -- restart from the initial pair after the
// final accept instead of stopping in DONE.
module operand_pattern_gen #(
    parameter int unsigned WIDTH     = 2,
    parameter logic [WIDTH-1:0] INIT_A = 1,
    parameter logic [WIDTH-1:0] INIT_B = 0,
    parameter int unsigned HOLD_A    = 50,
    parameter int unsigned HOLD_B    = 100,
    parameter int unsigned NUM_STEPS = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done
);

    localparam int unsigned K_W = (NUM_STEPS < 1) ? 1 : $clog2(NUM_STEPS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESENT,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [K_W-1:0]   k;
    logic [CNT_W-1:0] timer;

    logic do_clear;
    logic do_load;
    logic do_arm;
    logic do_step;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and datapath strobes; abort overrides everything.
    always_comb begin
        state_nxt = state;
        do_clear  = 1'b0;
        do_load   = 1'b0;
        do_arm    = 1'b0;
        do_step   = 1'b0;
        if (abort) begin
            state_nxt = S_IDLE;
            do_clear  = 1'b1;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_nxt = S_PRESENT;
                        do_load   = 1'b1;
                    end
                end
                S_PRESENT: begin
                    if (out_ready) begin
                        if (k == K_W'(NUM_STEPS)) begin
`ifdef OPGEN_LOOP_EN
                            state_nxt = S_PRESENT;
                            do_load   = 1'b1;
`else
                            state_nxt = S_DONE;
`endif
                        end else begin
                            state_nxt = S_WAIT;
                            do_arm    = 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (timer == CNT_W'(1)) begin
                        state_nxt = S_PRESENT;
                        do_step   = 1'b1;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Operand, pair index and hold-timer registers.
    always_ff @(posedge clk) begin
        if (!rst_n || do_clear) begin
            a     <= '0;
            b     <= '0;
            k     <= '0;
            timer <= '0;
        end else if (do_load) begin
            a     <= INIT_A;
            b     <= INIT_B;
            k     <= '0;
            timer <= '0;
        end else if (do_arm) begin
            timer <= k[0] ? CNT_W'(HOLD_B) : CNT_W'(HOLD_A);
        end else if (do_step) begin
            if (k[0]) begin
                b <= ~b;
            end else begin
                a <= ~a;
            end
            k     <= k + K_W'(1);
            timer <= '0;
        end else if (state == S_WAIT) begin
            timer <= timer - CNT_W'(1);
        end
    end

    assign out_valid = (state == S_PRESENT);
    assign busy      = (state == S_PRESENT) || (state == S_WAIT);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_operand_pattern_gen.sv
// Self-checking bench for operand_pattern_gen: expected pairs and gap lengths
// come from a sequence-level model of the invert-a / invert-b rule.
// Honours OPGEN_LOOP_EN the same way as the design.
module tb_operand_pattern_gen;

    localparam int unsigned WIDTH     = 2;
    localparam logic [1:0]  INIT_A    = 2'b01;
    localparam logic [1:0]  INIT_B    = 2'b00;
    localparam int unsigned HOLD_A    = 50;
    localparam int unsigned HOLD_B    = 100;
    localparam int unsigned NUM_STEPS = 4;
    localparam int unsigned CNT_W     = 8;
`ifdef OPGEN_LOOP_EN
    localparam bit LOOP  = 1'b1;
    localparam int LOOPS = 2;
`else
    localparam bit LOOP  = 1'b0;
    localparam int LOOPS = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic out_ready = 1'b1;
    logic out_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic busy;
    logic done;

    int checks = 0;
    int failures = 0;

    operand_pattern_gen #(
        .WIDTH(WIDTH), .INIT_A(INIT_A), .INIT_B(INIT_B),
        .HOLD_A(HOLD_A), .HOLD_B(HOLD_B), .NUM_STEPS(NUM_STEPS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .out_ready(out_ready), .out_valid(out_valid), .a(a), .b(b),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Pair j of the sequence: start from the initial pair, then invert a on
    // even steps and b on odd steps.
    function automatic logic [3:0] exp_pair(input int j);
        logic [1:0] ea;
        logic [1:0] eb;
        ea = INIT_A;
        eb = INIT_B;
        for (int i = 0; i < j; i++) begin
            if (i % 2 == 0) ea = ~ea;
            else            eb = ~eb;
        end
        return {ea, eb};
    endfunction

    // Idle gap that follows the accept of pair j.
    function automatic int exp_gap(input int j);
        return (j % 2 == 0) ? int'(HOLD_A) : int'(HOLD_B);
    endfunction

    task automatic pulse_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checks++; if (a !== 2'b00) begin failures++; $display("FAIL reset_a got=%b exp=00", a); end
        checks++; if (b !== 2'b00) begin failures++; $display("FAIL reset_b got=%b exp=00", b); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    endtask

    // mode 0: always ready; 1: random ready; 2: ready held low 20 cycles on pair 1.
    // inject: pulse start in the middle of the first gap (must be ignored).
    task automatic run_sequence(input int mode, input int loops, input bit inject);
        int total;
        int j;
        int gap;
        int hc;
        int egap;
        bit rdy;
        logic [3:0] ep;
        total = loops * (NUM_STEPS + 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int p = 0; p < total; p++) begin
            j = p % (NUM_STEPS + 1);
            gap = 0;
            while (out_valid !== 1'b1 && gap <= int'(HOLD_B) + 5) begin
                start = (inject && p == 1 && gap == 10);
                out_ready = (mode == 1) ? 1'($urandom) : 1'b1;
                @(negedge clk);
                gap++;
            end
            start = 1'b0;
            egap = (j == 0) ? 0 : exp_gap(j - 1);
            checks++;
            if (gap !== egap) begin
                failures++;
                $display("FAIL gap_before_pair%0d got=%0d exp=%0d", j, gap, egap);
                if (out_valid !== 1'b1) return;
            end
            ep = exp_pair(j);
            hc = 0;
            do begin
                checks++;
                if ({a, b} !== ep || out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                    failures++;
                    $display("FAIL pair%0d got a=%b b=%b v=%b busy=%b done=%b exp a=%b b=%b v=1 busy=1 done=0",
                             j, a, b, out_valid, busy, done, ep[3:2], ep[1:0]);
                end
                case (mode)
                    1:       rdy = ($urandom_range(3) != 0);
                    2:       rdy = !(j == 1 && hc < 20);
                    default: rdy = 1'b1;
                endcase
                if (hc > 200) rdy = 1'b1;
                out_ready = rdy;
                @(negedge clk);
                hc++;
            end while (!rdy);
            out_ready = 1'b1;
        end
        if (LOOP) begin
            ep = exp_pair(0);
            checks++;
            if ({a, b} !== ep || out_valid !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL loop_restart got a=%b b=%b v=%b done=%b exp a=%b b=%b v=1 done=0",
                         a, b, out_valid, done, ep[3:2], ep[1:0]);
            end
        end else begin
            ep = exp_pair(NUM_STEPS);
            checks++;
            if ({a, b} !== ep || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
                failures++;
                $display("FAIL final_done got a=%b b=%b v=%b busy=%b done=%b exp a=%b b=%b v=0 busy=0 done=1",
                         a, b, out_valid, busy, done, ep[3:2], ep[1:0]);
            end
        end
    endtask

    task automatic test_full_sequence();
        run_sequence(0, LOOPS, 1'b0);
        if (LOOP) pulse_abort();
    endtask

    task automatic test_backpressure();
        run_sequence(2, 1, 1'b0);
        if (LOOP) pulse_abort();
    endtask

    task automatic test_abort_mid_wait();
        logic [3:0] ep;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        // now in WAIT cycle 1; advance to cycle 30
        repeat (29) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre_wait got v=%b busy=%b exp v=0 busy=1", out_valid, busy);
        end
        pulse_abort();
        checks++;
        if ({a, b} !== 4'b0000 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle got a=%b b=%b v=%b busy=%b done=%b exp 00 00 0 0 0",
                     a, b, out_valid, busy, done);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ep = exp_pair(0);
        checks++;
        if ({a, b} !== ep || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL abort_restart got a=%b b=%b v=%b exp a=%b b=%b v=1",
                     a, b, out_valid, ep[3:2], ep[1:0]);
        end
        pulse_abort();
    endtask

    task automatic test_start_ignored();
        run_sequence(0, 1, 1'b1);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if ({a, b} !== 4'b0000 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_wins got a=%b b=%b v=%b busy=%b done=%b exp 00 00 0 0 0",
                     a, b, out_valid, busy, done);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            run_sequence(1, LOOPS, 1'b0);
            if (LOOP) pulse_abort();
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_full_sequence();
        test_backpressure();
        test_abort_mid_wait();
        test_start_ignored();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
